alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/common_pkg.sv | 27 ++
 rtl/alu_shifter.sv | 40 ++++
 rtl/alu.sv | 62 ++++++
 tb/tb_alu.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared datapath types: 64-bit word and ALU operation encoding
package common;

    typedef logic [63:0] u64;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_SLLW   = 5'd11,
        ALU_SRLW   = 5'd12,
        ALU_SRAW   = 5'd13,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19
    } ALU_OP;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - 64-bit and 32-bit-word shifts for the ALU
// Word results are sign-extended from bit 31; non-shift ops return zero.
module alu_shifter
    import common::*;
(
    input  u64          i_a,
    input  logic [5:0]  i_shamt,
    input  ALU_OP       i_op,
    output u64          o_result
);

    logic [31:0] w_word;
    logic [4:0]  w_wshamt;

    assign w_wshamt = i_shamt[4:0];

    always_comb begin
        w_word   = '0;
        o_result = '0;
        case (i_op)
            ALU_SLL:  o_result = i_a << i_shamt;
            ALU_SRL:  o_result = i_a >> i_shamt;
            ALU_SRA:  o_result = $signed(i_a) >>> i_shamt;
            ALU_SLLW: begin
                w_word   = i_a[31:0] << w_wshamt;
                o_result = {{32{w_word[31]}}, w_word};
            end
            ALU_SRLW: begin
                w_word   = i_a[31:0] >> w_wshamt;
                o_result = {{32{w_word[31]}}, w_word};
            end
            ALU_SRAW: begin
                w_word   = $signed(i_a[31:0]) >>> w_wshamt;
                o_result = {{32{w_word[31]}}, w_word};
            end
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - combinational 64-bit ALU; multiply ops enabled by macro ALU_MUL_EN
// clk and rst exist only for interface uniformity; no state is held.
module alu
    import common::*;
(
    input  logic        clk,
    input  logic        rst,
    input  u64          ia,
    input  u64          ib,
    input  logic [4:0]  aluOp,
    output u64          aluOut
);

    ALU_OP w_op;
    u64    w_shift;
    logic  w_unused_clk_rst;

    assign w_op             = ALU_OP'(aluOp);
    assign w_unused_clk_rst = clk ^ rst;

    alu_shifter u_shifter (
        .i_a      (ia),
        .i_shamt  (ib[5:0]),
        .i_op     (w_op),
        .o_result (w_shift)
    );

`ifdef ALU_MUL_EN
    // One shared 128-bit multiplier; operand extension picks the signedness.
    logic         w_a_signed;
    logic         w_b_signed;
    logic [127:0] w_prod;

    assign w_a_signed = (w_op == ALU_MULH) || (w_op == ALU_MULHSU);
    assign w_b_signed = (w_op == ALU_MULH);
    assign w_prod     = {{64{w_a_signed & ia[63]}}, ia} * {{64{w_b_signed & ib[63]}}, ib};
`endif

    always_comb begin
        aluOut = '0;
        case (w_op)
            ALU_ADD:   aluOut = ia + ib;
            ALU_SUB:   aluOut = ia - ib;
            ALU_AND:   aluOut = ia & ib;
            ALU_OR:    aluOut = ia | ib;
            ALU_XOR:   aluOut = ia ^ ib;
            ALU_SLT:   aluOut = {63'b0, $signed(ia) < $signed(ib)};
            ALU_SLTU:  aluOut = {63'b0, ia < ib};
            ALU_PASSB: aluOut = ib;
            ALU_SLL, ALU_SRL, ALU_SRA,
            ALU_SLLW, ALU_SRLW, ALU_SRAW:
                       aluOut = w_shift;
`ifdef ALU_MUL_EN
            ALU_MUL:   aluOut = w_prod[63:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:
                       aluOut = w_prod[127:64];
`endif
            default:   aluOut = '0;
        endcase
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed and randomized checks of alu against an arithmetic reference
module tb_alu;

    logic        clk;
    logic        rst;
    logic [63:0] ia;
    logic [63:0] ib;
    logic [4:0]  aluOp;
    logic [63:0] aluOut;

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .ia     (ia),
        .ib     (ib),
        .aluOp  (aluOp),
        .aluOut (aluOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [31:0]         w;
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        logic [127:0]        ua;
        logic [127:0]        ub;
        logic [127:0]        p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {64'b0, a};
        ub = {64'b0, b};
        p  = '0;
        w  = '0;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[5:0];
            5'd6:  return a >> b[5:0];
            5'd7:  return $signed(a) >>> b[5:0];
            5'd8:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            5'd9:  return (a < b) ? 64'd1 : 64'd0;
            5'd10: return b;
            5'd11: begin w = a[31:0] << b[4:0];          return {{32{w[31]}}, w}; end
            5'd12: begin w = a[31:0] >> b[4:0];          return {{32{w[31]}}, w}; end
            5'd13: begin w = $signed(a[31:0]) >>> b[4:0]; return {{32{w[31]}}, w}; end
`ifdef ALU_MUL_EN
            5'd16: return a * b;
            5'd17: begin p = sa * sb; return p[127:64]; end
            5'd18: begin p = sa * ub; return p[127:64]; end
            5'd19: begin p = ua * ub; return p[127:64]; end
`endif
            default: return 64'd0;
        endcase
    endfunction

    task automatic apply(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        aluOp = op;
        ia    = a;
        ib    = b;
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] expected);
        checks++;
        assert (aluOut === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (op %0d ia %h ib %h)", tag, aluOut, expected, aluOp, ia, ib);
        end
    endtask

    initial begin
        rst   = 1'b1;
        aluOp = 5'd0;
        ia    = 64'd0;
        ib    = 64'd0;
        #2;
        check("reset_add_zero", 64'd0);
        apply(5'd0, 64'd7, 64'd9);
        check("add_during_reset", 64'd16);
        rst = 1'b0;

        apply(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("add_wrap", 64'd0);
        apply(5'd1, 64'd0, 64'd1);
        check("sub_wrap", 64'hFFFF_FFFF_FFFF_FFFF);
        apply(5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("slt_neg", 64'd1);
        apply(5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("sltu_big", 64'd0);
        apply(5'd7, 64'h8000_0000_0000_0000, 64'h43);
        check("sra_shamt_mask", 64'hF000_0000_0000_0000);
        apply(5'd12, 64'hFFFF_FFFF_8000_0000, 64'd1);
        check("srlw", 64'h0000_0000_4000_0000);
        apply(5'd13, 64'hFFFF_FFFF_8000_0000, 64'd1);
        check("sraw", 64'hFFFF_FFFF_C000_0000);
        apply(5'd11, 64'h1234_5678_0000_0001, 64'h3F);
        check("sllw_shamt31", 64'hFFFF_FFFF_8000_0000);
        apply(5'd5, 64'd1, 64'hFFC1);
        check("sll_shamt_mask", 64'd2);
        apply(5'd6, 64'h8000_0000_0000_0000, 64'd63);
        check("srl_63", 64'd1);
        apply(5'd10, 64'h1111, 64'hDEAD_BEEF_CAFE_F00D);
        check("passb", 64'hDEAD_BEEF_CAFE_F00D);
        apply(5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("op14_zero", 64'd0);
        apply(5'd31, 64'h5555, 64'hAAAA);
        check("op31_zero", 64'd0);

`ifdef ALU_MUL_EN
        apply(5'd19, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mulhu_max", 64'hFFFF_FFFF_FFFF_FFFE);
        apply(5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mulh_neg1", 64'd0);
        apply(5'd18, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mulhsu_neg1", 64'hFFFF_FFFF_FFFF_FFFF);
`else
        apply(5'd16, 64'd6, 64'd7);
        check("mul_disabled", 64'd0);
        apply(5'd19, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mulhu_disabled", 64'd0);
`endif

        apply(5'd0, 64'd2, 64'd3);
        check("add_pre_rst", 64'd5);
        rst = 1'b1;
        #1;
        check("add_rst_assert", 64'd5);
        @(posedge clk);
        #1;
        check("add_rst_edge", 64'd5);
        @(negedge clk);
        check("add_rst_held", 64'd5);
        rst = 1'b0;
        #1;
        check("add_rst_release", 64'd5);
        @(posedge clk);
        #1;
        check("add_after_rst", 64'd5);

        for (int i = 0; i < 400; i++) begin
            logic [4:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            op = 5'($urandom_range(0, 31));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if (i % 4 == 1) b = 64'($urandom_range(0, 255));
            if (i % 8 == 3) a[63] = 1'b1;
            if (i % 8 == 5) a[31] = 1'b1;
            apply(op, a, b);
            check("random", ref_alu(op, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
